mbtrain_step_rx: RTL and testbench
==================================

# mbtrain_step_rx

Parametrised partner-side responder for multi-step MBTRAIN sub-states. It answers a sequence of `N_PAIRS` sideband request/response handshakes, one response per expected request, in strict order. It shares the sideband transmit path with its TX-side sibling through the `i_valid_tx` / `i_busy_negedge_detected` arbitration. It raises `o_test_ack` after the last pair and, optionally, flags a handshake timeout.

## Interface
- `MSG_W`, 4, width of the decoded/encoded sideband message code
- `N_PAIRS`, 2, number of request/response pairs per run, 1..(2^(MSG_W-1)-1)
- `TIMEOUT_W`, 16, timeout counter width (used only with the macro)
- `TIMEOUT_CYC`, 8000, cycles allowed per wait/send state (used only with the macro)

Ports:
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_en`  in  1  run enable; level-sensitive
- `i_decoded_sideband_message`  in  MSG_W  received message code, 0 = none
- `i_valid_tx`  in  1  TX sibling currently owns the sideband path
- `i_busy_negedge_detected`  in  1  one-cycle pulse: sideband accepted the current message
- `o_sideband_message`  out  MSG_W  response code to send
- `o_valid_rx`  out  1  response valid toward sideband
- `o_pair_idx`  out  clog2(N_PAIRS)+1 bits  index of the pair in progress
- `o_test_ack`  out  1  all pairs completed
- `o_error`  out  1  handshake timeout

## Operation
- Code map: the request for pair k is 2k+1 and the response for pair k is 2k+2, so k=0 gives 0001→0010.
- States are IDLE, WAIT_REQ, SEND_RESP, DONE and ERROR. ERROR exists only with the macro.
- IDLE→WAIT_REQ when `i_en`=1; `o_pair_idx` is set to 0.
- WAIT_REQ→SEND_RESP when the input message equals 2·idx+1. Any other code is ignored, including requests for other pairs.
- SEND_RESP→WAIT_REQ with idx+1 on the falling edge of `o_valid_rx`, provided idx<N_PAIRS-1.
  - On the last pair the transition goes to DONE instead.
  - `o_sideband_message` is set to 0 on exit.
- DONE holds `o_test_ack`=1 until `i_en`=0, then returns to IDLE.
- Valid handling:
  - `pending` is set on entry to SEND_RESP.
  - `o_valid_rx` is set when (entry or `pending`) and `i_valid_tx`=0.
  - `o_valid_rx` is cleared by `i_busy_negedge_detected`; the clear has priority over a simultaneous set.
  - `pending` is cleared when `i_busy_negedge_detected` arrives while `o_valid_rx`=1.
- `i_en`=0 in any non-IDLE state forces IDLE on the next edge. All outputs and `pending` are cleared, aborting any in-flight response.
- Reset values: all outputs 0, state IDLE, idx 0, `pending` 0.

## Timing
- Request seen in cycle t with `i_valid_tx`=0: at edge t+1, state is SEND_RESP, the message is the response code and `o_valid_rx`=1.
- If `i_valid_tx`=1 at t, `o_valid_rx` rises at the first edge after a cycle with `i_valid_tx`=0. The message is already stable from t+1.
- `i_busy_negedge_detected` in cycle b: `o_valid_rx`=0 at b+1, falling edge seen during b+1, next state at b+2. On the last pair `o_test_ack`=1 at b+2.
- Minimum per pair: 1 request cycle plus 2 cycles after busy negedge.
- `i_busy_negedge_detected` while `o_valid_rx`=0 is ignored.

## Configuration
- `MBTRAIN_RX_TIMEOUT_EN` defined:
  - A TIMEOUT_W counter is zeroed on entry to WAIT_REQ or SEND_RESP and counts every cycle in those states.
  - At TIMEOUT_CYC-1 the next state is ERROR.
  - In ERROR, `o_error`=1, `o_valid_rx`=0 and the message is 0; the block stays there until `i_en`=0.
  - The counter saturates and never wraps.
- Not defined: no counter and no ERROR state; `o_error` is tied 0.

## Structure
- Package `mbtrain_rx_pkg` holds:
  - the state encoding constants;
  - the `req_code(k)` and `resp_code(k)` functions;
  - the `IDX_W` constant.
- Sub-module `sb_valid_arbiter` holds the `pending`/`o_valid_rx` set/clear logic, the registered copy of valid and the falling-edge pulse output. It is reusable by the TX sibling.

## Test plan
- N_PAIRS=2, `i_en`=1, send 0001, busy pulse, then 0011, busy pulse → responses 0010 then 0100; `o_test_ack`=1 two cycles after the second busy pulse.
- `i_valid_tx`=1 for 5 cycles when 0001 arrives → `o_valid_rx` rises only after `i_valid_tx` falls; message 0010 is stable from the first cycle.
- In WAIT_REQ with idx=0, send 0011 and 0101 → no state change, `o_valid_rx` stays 0; then 0001 → normal response.
- Drop `i_en` while `o_valid_rx`=1 → next edge: IDLE, all outputs 0; re-enabling restarts at idx 0.
- Busy pulse in the same cycle as a valid set → `o_valid_rx` stays 0.
- With the macro, TIMEOUT_CYC=16 and no request → `o_error`=1 exactly 16 cycles after entering WAIT_REQ; cleared by `i_en`=0.

Source files
------------

// File: rtl/mbtrain_rx_pkg.sv
// rtl/mbtrain_rx_pkg.sv - state encoding, code map and index width for the MBTRAIN step responder
package mbtrain_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_SEND_RESP = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  // One extra bit so the index can also represent N_PAIRS itself
  function automatic int idx_width(input int n_pairs);
    return $clog2(n_pairs) + 1;
  endfunction

  localparam int N_PAIRS_DEF = 2;
  localparam int IDX_W       = idx_width(N_PAIRS_DEF);

  function automatic int unsigned req_code(input int unsigned k);
    return 2 * k + 1;
  endfunction

  function automatic int unsigned resp_code(input int unsigned k);
    return 2 * k + 2;
  endfunction

endpackage

// File: rtl/sb_valid_arbiter.sv
// rtl/sb_valid_arbiter.sv - sideband valid/pending handshake shared by the RX and TX step engines
module sb_valid_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set,
  input  logic blocked,
  input  logic busy_negedge,
  output logic valid,
  output logic valid_fall
);

  logic pending;
  logic valid_d;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pending <= 1'b0;
      valid   <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      valid_d <= valid;
      if (set)
        pending <= 1'b1;
      else if (busy_negedge && valid)
        pending <= 1'b0;
      // An acceptance pulse wins over a simultaneous raise; pending retries it next cycle
      if (busy_negedge)
        valid <= 1'b0;
      else if ((set || pending) && !blocked)
        valid <= 1'b1;
    end
  end

  assign valid_fall = valid_d & ~valid;

endmodule

// File: rtl/mbtrain_step_rx.sv
// rtl/mbtrain_step_rx.sv - partner-side responder answering N_PAIRS sideband request/response pairs
// Optional handshake timeout: define MBTRAIN_RX_TIMEOUT_EN.
module mbtrain_step_rx
  import mbtrain_rx_pkg::*;
#(
  parameter int MSG_W       = 4,
  parameter int N_PAIRS     = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 8000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [MSG_W-1:0]         i_decoded_sideband_message,
  input  logic                     i_valid_tx,
  input  logic                     i_busy_negedge_detected,
  output logic [MSG_W-1:0]         o_sideband_message,
  output logic                     o_valid_rx,
  output logic [$clog2(N_PAIRS):0] o_pair_idx,
  output logic                     o_test_ack,
  output logic                     o_error
);

  localparam int PIDX_W = idx_width(N_PAIRS);
  localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(N_PAIRS - 1);

  if (N_PAIRS < 1 || N_PAIRS > (1 << (MSG_W - 1)) - 1 || TIMEOUT_W < 1 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("mbtrain_step_rx: parameter out of range");
  end

  state_t            state;
  logic [PIDX_W-1:0] idx;
  logic [MSG_W-1:0]  req_now;
  logic [MSG_W-1:0]  resp_now;
  logic              abort;
  logic              req_hit;
  logic              resp_done;
  logic              valid_fall;
  logic              to_error;

  assign req_now   = MSG_W'(req_code(32'(idx)));
  assign resp_now  = MSG_W'(resp_code(32'(idx)));
  assign abort     = (state != ST_IDLE) && !i_en;
  assign req_hit   = (state == ST_WAIT_REQ) && i_en && (i_decoded_sideband_message == req_now);
  assign resp_done = (state == ST_SEND_RESP) && valid_fall;

`ifdef MBTRAIN_RX_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 in_timed;

  assign in_timed = (state == ST_WAIT_REQ) || (state == ST_SEND_RESP);
  // A handshake completing in the final cycle still counts as progress
  assign to_error = in_timed && i_en && (tmo_cnt == TMO_LAST) && !req_hit && !resp_done;

  always_ff @(posedge clk) begin
    if (rst || !in_timed || req_hit || resp_done)
      tmo_cnt <= '0;
    else if (tmo_cnt != '1)
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || abort)
      o_error <= 1'b0;
    else if (to_error)
      o_error <= 1'b1;
  end
`else
  assign to_error = 1'b0;
  assign o_error  = 1'b0;
`endif

  sb_valid_arbiter u_valid (
    .clk          (clk),
    .rst          (rst),
    .clr          (abort | to_error),
    .set          (req_hit),
    .blocked      (i_valid_tx),
    .busy_negedge (i_busy_negedge_detected),
    .valid        (o_valid_rx),
    .valid_fall   (valid_fall)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state              <= ST_IDLE;
      idx                <= '0;
      o_sideband_message <= '0;
      o_test_ack         <= 1'b0;
    end else if (to_error) begin
      state              <= ST_ERROR;
      o_sideband_message <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_en) begin
            state <= ST_WAIT_REQ;
            idx   <= '0;
          end
        end
        ST_WAIT_REQ: begin
          if (req_hit) begin
            state              <= ST_SEND_RESP;
            o_sideband_message <= resp_now;
          end
        end
        ST_SEND_RESP: begin
          if (valid_fall) begin
            o_sideband_message <= '0;
            if (idx == LAST_IDX) begin
              state      <= ST_DONE;
              o_test_ack <= 1'b1;
            end else begin
              state <= ST_WAIT_REQ;
              idx   <= idx + PIDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pair_idx = idx;

endmodule

// File: tb/tb_mbtrain_step_rx.sv
// tb/tb_mbtrain_step_rx.sv - table-driven bench for mbtrain_step_rx
module tb_mbtrain_step_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic [3:0] i_decoded_sideband_message;
  logic       i_valid_tx;
  logic       i_busy_negedge_detected;
  logic [3:0] o_sideband_message;
  logic       o_valid_rx;
  logic [1:0] o_pair_idx;
  logic       o_test_ack;
  logic       o_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mbtrain_step_rx #(
    .MSG_W       (4),
    .N_PAIRS     (2),
    .TIMEOUT_W   (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .i_en                       (i_en),
    .i_decoded_sideband_message (i_decoded_sideband_message),
    .i_valid_tx                 (i_valid_tx),
    .i_busy_negedge_detected    (i_busy_negedge_detected),
    .o_sideband_message         (o_sideband_message),
    .o_valid_rx                 (o_valid_rx),
    .o_pair_idx                 (o_pair_idx),
    .o_test_ack                 (o_test_ack),
    .o_error                    (o_error)
  );

  typedef struct {
    int en; int msg; int vtx; int busy;
    int e_msg; int e_v; int e_idx; int e_ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int en, input int msg, input int vtx, input int busy,
                              input int e_msg, input int e_v, input int e_idx, input int e_ack);
    vec_t r;
    r.en = en; r.msg = msg; r.vtx = vtx; r.busy = busy;
    r.e_msg = e_msg; r.e_v = e_v; r.e_idx = e_idx; r.e_ack = e_ack;
    return r;
  endfunction

  task automatic chk(input string name, input int n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, n, act, exp);
    end
  endtask

  task automatic step(input int en, input int msg, input int vtx, input int busy);
    @(negedge clk);
    i_en                       = en[0];
    i_decoded_sideband_message = msg[3:0];
    i_valid_tx                 = vtx[0];
    i_busy_negedge_detected    = busy[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_en = 1'b0;
    i_decoded_sideband_message = 4'h0;
    i_valid_tx = 1'b0;
    i_busy_negedge_detected = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_msg",   0, int'(o_sideband_message), 0);
    chk("rst_valid", 0, int'(o_valid_rx), 0);
    chk("rst_idx",   0, int'(o_pair_idx), 0);
    chk("rst_ack",   0, int'(o_test_ack), 0);
    chk("rst_err",   0, int'(o_error), 0);
    @(negedge clk);
    rst = 1'b0;

    //                en msg vtx busy | msg v idx ack
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0));  // enter WAIT_REQ
    tbl.push_back(mk(1, 3, 0, 0,  0, 0, 0, 0));  // other pair's request ignored
    tbl.push_back(mk(1, 5, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  2, 1, 0, 0));  // pair 0 request -> response
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1,  2, 0, 0, 0));  // accepted
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 0));  // falling edge -> pair 1
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0));  // stale pair 0 request ignored
    tbl.push_back(mk(1, 3, 1, 0,  4, 0, 1, 0));  // TX owns the path
    tbl.push_back(mk(1, 0, 1, 0,  4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  4, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1,  4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 1));  // ack two cycles after busy
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));  // disable -> IDLE
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,  2, 0, 0, 0));  // TX busy for 5 cycles
    tbl.push_back(mk(1, 0, 1, 0,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 3, 0, 0,  4, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));  // abort in-flight response
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0));  // restart at pair 0
    tbl.push_back(mk(1, 1, 0, 1,  2, 0, 0, 0));  // busy on the set cycle wins
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1,  2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].msg, tbl[i].vtx, tbl[i].busy);
      chk("msg",   i, int'(o_sideband_message), tbl[i].e_msg);
      chk("valid", i, int'(o_valid_rx), tbl[i].e_v);
      chk("idx",   i, int'(o_pair_idx), tbl[i].e_idx);
      chk("ack",   i, int'(o_test_ack), tbl[i].e_ack);
      chk("err",   i, int'(o_error), 0);
    end

    // Stray busy pulse in WAIT_REQ, then a bounded pair-1 handshake
    step(1, 0, 0, 1);
    chk("stray_busy_valid", 100, int'(o_valid_rx), 0);
    chk("stray_busy_idx",   100, int'(o_pair_idx), 1);
    step(1, 3, 0, 0);
    n = 0;
    while (o_valid_rx !== 1'b1 && n < 4) begin
      step(1, 0, 0, 0);
      n++;
    end
    chk("req1_valid",   101, int'(o_valid_rx), 1);
    chk("req1_latency", 101, n, 0);
    chk("req1_msg",     101, int'(o_sideband_message), 4);
    step(1, 0, 0, 1);
    n = 1;
    while (o_test_ack !== 1'b1 && n < 6) begin
      step(1, 0, 0, 0);
      n++;
    end
    chk("done_ack",     102, int'(o_test_ack), 1);
    chk("done_latency", 102, n, 2);
    step(0, 0, 0, 0);
    chk("done_clear", 103, int'(o_test_ack), 0);

`ifdef MBTRAIN_RX_TIMEOUT_EN
    step(1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0);
      chk("tmo_err", 200 + k, int'(o_error), (k == 16) ? 1 : 0);
    end
    chk("tmo_valid", 217, int'(o_valid_rx), 0);
    chk("tmo_msg",   217, int'(o_sideband_message), 0);
    step(1, 1, 0, 0);
    chk("tmo_hold", 218, int'(o_error), 1);
    step(0, 0, 0, 0);
    chk("tmo_clear", 219, int'(o_error), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
